// File: rtl/debug_slave_pkg.sv
// Shared defaults and the command record for the sysclk-side JTAG debug command queue.
package debug_slave_pkg;

   localparam int DEF_DR_WIDTH    = 38;
   localparam int DEF_IR_WIDTH    = 2;
   localparam int DEF_DEPTH       = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_ACTION_BIT  = 37;

   typedef struct packed {
      logic [DEF_IR_WIDTH-1:0] ir;
      logic [DEF_DR_WIDTH-1:0] dr;
   } dbg_cmd_t;

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain strobe with a single-cycle rising-edge pulse.
module dbg_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              edge_q;

   // Reset-to-1 so a strobe already high at reset release never looks like a new edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         edge_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         edge_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/debug_slave_cmdq.sv
// Sysclk-side debug command receiver: syncs update strobes, queues {ir, dr} and pulses action vectors on pop.
module debug_slave_cmdq
   import debug_slave_pkg::*;
#(
   parameter int DR_WIDTH    = DEF_DR_WIDTH,
   parameter int IR_WIDTH    = DEF_IR_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int ACTION_BIT  = DEF_ACTION_BIT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      vs_uir,
   input  logic                      vs_udr,
   input  logic [IR_WIDTH-1:0]       ir_in,
   input  logic [DR_WIDTH-1:0]       sr,
   input  logic                      cmd_ready,
   input  logic                      ovf_clr,
   output logic                      cmd_valid,
   output logic [IR_WIDTH-1:0]       cmd_ir,
   output logic [DR_WIDTH-1:0]       jdo,
   output logic [2**IR_WIDTH-1:0]    take_action,
   output logic [2**IR_WIDTH-1:0]    take_no_action,
   output logic                      ovf,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int AW   = $clog2(DEPTH);
   localparam int NACT = 2**IR_WIDTH;

   typedef struct packed {
      logic [IR_WIDTH-1:0] ir;
      logic [DR_WIDTH-1:0] dr;
   } cmd_t;

   cmd_t            mem_q [DEPTH];
   cmd_t            last_q, head;
   logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic            ovf_q, ovf_d;
   logic [NACT-1:0] act_q, act_d, noact_q, noact_d;
   logic            uir_rise, udr_rise, push, pop, full, empty, wr_en;

   dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_sync (
      .clk(clk), .rst(reset), .async_i(vs_uir), .rise_o(uir_rise)
   );

   dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
      .clk(clk), .rst(reset), .async_i(vs_udr), .rise_o(udr_rise)
   );

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push  = udr_rise;
   assign pop   = ~empty & cmd_ready;
   // A pop frees the slot in the same edge, so a full queue still accepts then.
   assign wr_en = push & (~full | pop);

   // Head falls back to the last popped entry so outputs hold while empty.
   assign head = empty ? last_q : mem_q[rptr_q[AW-1:0]];

   always_comb begin
      ir_d    = ir_q;
      wptr_d  = wptr_q + (AW+1)'(wr_en);
      rptr_d  = rptr_q + (AW+1)'(pop);
      ovf_d   = ovf_q;
      act_d   = '0;
      noact_d = '0;
      if (uir_rise) ir_d = ir_in;
      if (push && full && !pop) ovf_d = 1'b1;
      else if (ovf_clr)         ovf_d = 1'b0;
      if (pop) begin
         if (head.dr[ACTION_BIT]) act_d[head.ir]   = 1'b1;
         else                     noact_d[head.ir] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         ir_q    <= '0;
         ovf_q   <= 1'b0;
         act_q   <= '0;
         noact_q <= '0;
         last_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ir_q    <= ir_d;
         ovf_q   <= ovf_d;
         act_q   <= act_d;
         noact_q <= noact_d;
         if (pop) last_q <= head;
      end
   end

   // Storage is write-only from the pointer's view; ir_q here is the pre-update value.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= '{ir: ir_q, dr: sr};
   end

   assign cmd_valid      = ~empty;
   assign cmd_ir         = head.ir;
   assign jdo            = head.dr;
   assign take_action    = act_q;
   assign take_no_action = noact_q;
   assign ovf            = ovf_q;
   assign level          = wptr_q - rptr_q;

endmodule
